// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list one register per
// memory transfer, then applies optional base writeback in a single finishing cycle.
module ldm_stm_sequencer #(
   parameter int unsigned AW         = 32,
   parameter int unsigned WORD_BYTES = 4
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          START,
   input  logic          L,
   input  logic          P,
   input  logic          U,
   input  logic          W,
   input  logic [3:0]    RN,
   input  logic [15:0]   REGLIST,
   input  logic [AW-1:0] BASE,
   input  logic          MEM_READY,
   input  logic [AW-1:0] RD_DATA,
   input  logic [AW-1:0] RF_RD,
   output logic          BUSY,
   output logic          DONE,
   output logic [3:0]    RF_RA,
   output logic [3:0]    RF_WA,
   output logic          RF_WE,
   output logic [AW-1:0] RF_WD,
   output logic          MEM_REQ,
   output logic          MEM_WE,
   output logic [AW-1:0] MEM_ADDR,
   output logic [AW-1:0] MEM_WD,
   output logic          PC_LOAD,
   output logic [AW-1:0] PC_WD
);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_FIN} state_t;

   state_t        state_q, state_d;
   logic          l_q, l_d;
   logic          w_q, w_d;
   logic [3:0]    rn_q, rn_d;
   logic [15:0]   reglist_q, reglist_d;
   logic [15:0]   pend_q, pend_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] wb_q, wb_d;

   logic [4:0]    n_cnt;
   logic [AW-1:0] step;
   logic [AW-1:0] span;
   logic [AW-1:0] start_addr;
   logic [3:0]    cur;

   always_comb begin
      n_cnt = '0;
      for (int unsigned i = 0; i < 16; i++) n_cnt = n_cnt + 5'(REGLIST[i]);
      step = AW'(WORD_BYTES);
      span = AW'(n_cnt) * step;
      // Lowest address of the block; registers then fill it upward in every mode.
      unique case ({P, U})
         2'b01:   start_addr = BASE;
         2'b11:   start_addr = BASE + step;
         2'b00:   start_addr = BASE - span + step;
         default: start_addr = BASE - span;
      endcase
   end

   always_comb begin
      cur = '0;
      for (int unsigned i = 16; i > 0; i--) begin
         if (pend_q[i-1]) cur = 4'(i - 1);
      end
   end

   always_comb begin
      state_d   = state_q;
      l_d       = l_q;
      w_d       = w_q;
      rn_d      = rn_q;
      reglist_d = reglist_q;
      pend_d    = pend_q;
      addr_d    = addr_q;
      wb_d      = wb_q;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      RF_RA     = '0;
      RF_WA     = '0;
      RF_WE     = 1'b0;
      RF_WD     = '0;
      MEM_REQ   = 1'b0;
      MEM_WE    = 1'b0;
      MEM_ADDR  = '0;
      MEM_WD    = '0;
      PC_LOAD   = 1'b0;
      PC_WD     = '0;
      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               l_d       = L;
               w_d       = W;
               rn_d      = RN;
               reglist_d = REGLIST;
               pend_d    = REGLIST;
               addr_d    = start_addr;
               wb_d      = U ? (BASE + span) : (BASE - span);
               state_d   = (n_cnt != '0) ? S_XFER : S_FIN;
            end
         end
         S_XFER: begin
            BUSY     = 1'b1;
            MEM_REQ  = 1'b1;
            MEM_ADDR = addr_q;
            MEM_WE   = ~l_q;
            if (!l_q) begin
               RF_RA  = cur;
               MEM_WD = RF_RD;
            end
            if (MEM_READY) begin
               pend_d = pend_q & (pend_q - 16'd1);
               addr_d = addr_q + step;
               if (l_q) begin
                  if (cur == 4'd15) begin
                     PC_LOAD = 1'b1;
                     PC_WD   = RD_DATA;
                  end else begin
                     RF_WE = 1'b1;
                     RF_WA = cur;
                     RF_WD = RD_DATA;
                  end
               end
               if (pend_d == '0) state_d = S_FIN;
            end
         end
         S_FIN: begin
            BUSY = 1'b1;
            DONE = 1'b1;
            if (w_q && (rn_q != 4'd15) && !(l_q && reglist_q[rn_q])) begin
               RF_WE = 1'b1;
               RF_WA = rn_q;
               RF_WD = wb_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         l_q       <= 1'b0;
         w_q       <= 1'b0;
         rn_q      <= '0;
         reglist_q <= '0;
         pend_q    <= '0;
         addr_q    <= '0;
         wb_q      <= '0;
      end else begin
         state_q   <= state_d;
         l_q       <= l_d;
         w_q       <= w_d;
         rn_q      <= rn_d;
         reglist_q <= reglist_d;
         pend_q    <= pend_d;
         addr_q    <= addr_d;
         wb_q      <= wb_d;
      end
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: a list-level reference model queues the
// expected transfers and writeback, and a negedge monitor checks what the DUT presents.
module tb_ldm_stm_sequencer;

   logic        CLK, RST_N, START, L, P, U, W, MEM_READY;
   logic [3:0]  RN;
   logic [15:0] REGLIST;
   logic [31:0] BASE, RD_DATA, RF_RD;
   logic        BUSY, DONE, RF_WE, MEM_REQ, MEM_WE, PC_LOAD;
   logic [3:0]  RF_RA, RF_WA;
   logic [31:0] RF_WD, MEM_ADDR, MEM_WD, PC_WD;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_done;
      logic [3:0]  rg;
      logic [31:0] addr;
      bit          store;
      bit          wb;
      logic [3:0]  wa;
      logic [31:0] wd;
   } exp_t;

   exp_t sbq[$];

   ldm_stm_sequencer #(.AW(32), .WORD_BYTES(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .L(L), .P(P), .U(U), .W(W),
      .RN(RN), .REGLIST(REGLIST), .BASE(BASE), .MEM_READY(MEM_READY),
      .RD_DATA(RD_DATA), .RF_RD(RF_RD), .BUSY(BUSY), .DONE(DONE),
      .RF_RA(RF_RA), .RF_WA(RF_WA), .RF_WE(RF_WE), .RF_WD(RF_WD),
      .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WD(MEM_WD),
      .PC_LOAD(PC_LOAD), .PC_WD(PC_WD)
   );

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] rf_f(input logic [3:0] r);
      return 32'hA500_0000 | ({28'd0, r} * 32'h0001_1111);
   endfunction

   assign RD_DATA = mem_f(MEM_ADDR);
   assign RF_RD   = rf_f(RF_RA);

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a block of N words starting at the lowest address, registers
   // ascending, then a single writeback decision.
   task automatic push_op(input bit l, input bit p, input bit u, input bit w,
                          input logic [3:0] rn, input logic [15:0] lst, input logic [31:0] base);
      int n;
      int k;
      logic [31:0] lo;
      exp_t e;
      n = $countones(lst);
      if (u) lo = base + (p ? 32'd4 : 32'd0);
      else   lo = base - 32'(4 * n) + (p ? 32'd0 : 32'd4);
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (lst[i]) begin
            e = '{is_done: 1'b0, rg: 4'(i), addr: lo + 32'(4 * k), store: !l, wb: 1'b0, wa: 4'd0, wd: 32'd0};
            sbq.push_back(e);
            k++;
         end
      end
      e.is_done = 1'b1;
      e.wb      = w && (rn != 4'd15) && !(l && lst[rn]);
      e.wa      = rn;
      e.wd      = u ? base + 32'(4 * n) : base - 32'(4 * n);
      sbq.push_back(e);
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (RST_N) begin
         if (MEM_REQ) begin
            if (sbq.size() == 0 || sbq[0].is_done) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req actual_addr=%h expected=no_request", MEM_ADDR);
            end else begin
               e = sbq[0];
               chk("xfer_addr", MEM_ADDR, e.addr);
               chk("xfer_we", 32'(MEM_WE), 32'(e.store));
               if (e.store) begin
                  chk("store_ra", 32'(RF_RA), 32'(e.rg));
                  chk("store_wd", MEM_WD, rf_f(e.rg));
               end
               if (MEM_READY) begin
                  void'(sbq.pop_front());
                  if (e.store) begin
                     chk("store_no_wr", 32'({RF_WE, PC_LOAD}), 32'd0);
                  end else if (e.rg == 4'd15) begin
                     chk("pc_load", 32'({PC_LOAD, RF_WE}), 32'b10);
                     chk("pc_wd", PC_WD, mem_f(e.addr));
                  end else begin
                     chk("load_we", 32'({RF_WE, PC_LOAD}), 32'b10);
                     chk("load_wa", 32'(RF_WA), 32'(e.rg));
                     chk("load_wd", RF_WD, mem_f(e.addr));
                  end
               end
            end
         end else if (DONE) begin
            if (sbq.size() == 0 || !sbq[0].is_done) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 expected=0 pending=%0d", sbq.size());
            end else begin
               e = sbq.pop_front();
               chk("wb_we", 32'(RF_WE), 32'(e.wb));
               if (e.wb) begin
                  chk("wb_wa", 32'(RF_WA), 32'(e.wa));
                  chk("wb_wd", RF_WD, e.wd);
               end
            end
         end else if (RF_WE || PC_LOAD || MEM_WE) begin
            checks++;
            errors++;
            $display("FAIL spurious_strobe actual=%b expected=000", {RF_WE, PC_LOAD, MEM_WE});
         end
      end
   end

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_ctl"}, 32'({BUSY, DONE, RF_WE, MEM_REQ, MEM_WE, PC_LOAD, RF_RA, RF_WA}), 32'd0);
      chk({nm, "_data"}, MEM_ADDR | MEM_WD | RF_WD | PC_WD, 32'd0);
   endtask

   // Called just after a rising edge; returns just after a rising edge.
   // wmode < 0: random MEM_READY; otherwise that many wait cycles per transfer.
   task automatic run_op(input bit l, input bit p, input bit u, input bit w,
                         input logic [3:0] rn, input logic [15:0] lst, input logic [31:0] base,
                         input int wmode, input bit extra);
      int cyc;
      int stalls;
      int stall_cnt;
      bit done_seen;
      L = l; P = p; U = u; W = w; RN = rn; REGLIST = lst; BASE = base;
      START = 1'b1;
      MEM_READY = 1'($urandom);
      push_op(l, p, u, w, rn, lst, base);
      @(posedge CLK); #1;
      START = 1'b0;
      L = 1'($urandom); P = 1'($urandom); U = 1'($urandom); W = 1'($urandom);
      RN = 4'($urandom); REGLIST = 16'($urandom); BASE = $urandom;
      cyc = 1; stalls = 0; stall_cnt = 0; done_seen = 1'b0;
      while (!done_seen && cyc < 300) begin
         if (MEM_REQ) begin
            if (wmode < 0) MEM_READY = ($urandom % 3) != 0;
            else if (stall_cnt < wmode) begin MEM_READY = 1'b0; stall_cnt++; end
            else begin MEM_READY = 1'b1; stall_cnt = 0; end
            if (!MEM_READY) stalls++;
         end else begin
            MEM_READY = 1'($urandom);
         end
         START = extra && (cyc == 2);
         @(negedge CLK); #2;
         if (DONE) done_seen = 1'b1;
         else begin
            @(posedge CLK); #1;
            cyc++;
         end
      end
      START = 1'b0;
      MEM_READY = 1'b0;
      if (!done_seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done expected=done_within_300");
         sbq.delete();
      end else begin
         chk("done_cycle", 32'(cyc), 32'($countones(lst) + 1 + stalls));
      end
      @(posedge CLK); #1;
      chk("queue_drained", 32'(sbq.size()), 32'd0);
   endtask

   task automatic reset_midway();
      L = 1'b1; P = 1'b0; U = 1'b1; W = 1'b1; RN = 4'd1; REGLIST = 16'h00F0; BASE = 32'h800;
      START = 1'b1;
      MEM_READY = 1'b1;
      push_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h00F0, 32'h800);
      @(posedge CLK); #1;
      // Second START while busy with a different list must be ignored.
      REGLIST = 16'h0003; BASE = 32'h0; L = 1'b0;
      START = 1'b1;
      chk("busy_in_xfer", 32'(BUSY), 32'd1);
      @(posedge CLK); #1;
      chk("second_start_ignored", MEM_ADDR, 32'h804);
      START = 1'b0;
      RST_N = 1'b0;
      sbq.delete();
      #1;
      chk_reset_outputs("midreset");
      @(negedge CLK); #1;
      chk_reset_outputs("midreset_hold");
      RST_N = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk_reset_outputs("post_reset_idle");
      run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h00F0, 32'h800, 0, 1'b0);
   endtask

   initial begin
      RST_N = 1'b0; START = 1'b0; L = 1'b0; P = 1'b0; U = 1'b0; W = 1'b0;
      RN = '0; REGLIST = '0; BASE = '0; MEM_READY = 1'b0;
      #12;
      chk_reset_outputs("reset");
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd4,  16'h000B, 32'h100, 0, 1'b0);
      run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 16'h8006, 32'h200, 0, 1'b0);
      run_op(1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  16'h8010, 32'h300, 2, 1'b0);
      run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  16'h0004, 32'h400, 0, 1'b0);
      run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  16'h0000, 32'h040, 0, 1'b0);
      run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  16'hFFFF, 32'h004, 1, 1'b0);
      run_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd15, 16'h0C01, 32'hFFFF_FFF8, 0, 1'b1);
      reset_midway();
      for (int t = 0; t < 40; t++) begin
         run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                (($urandom % 8) == 0) ? 16'h0 : 16'($urandom), $urandom,
                int'($urandom % 4) - 1, 1'($urandom));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Multi-cycle controller for ARM LDM/STM (block data transfer).
- Takes a 16-bit register list and a base value, then drives the register-file ports and the data-memory handshake, one register per transfer.
- Sits between the decoder and the register file / data memory; stalls the core while active.
- R15 is not stored in the register file: for loads, R15 goes to a dedicated PC load output; for stores, R15 is read through the register-file port, which returns R15 at address 15.

Parameters:
- AW, 32, address and data width.
- WORD_BYTES, 4, address increment per transfer.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  begin operation; sampled only in IDLE
- L  in  1  1 = load (LDM), 0 = store (STM)
- P  in  1  pre-index (1) or post-index (0)
- U  in  1  up (1) or down (0)
- W  in  1  base writeback enable
- RN  in  4  base register number
- REGLIST  in  16  register list; bit i = Ri
- BASE  in  AW  value of Rn, sampled at START
- MEM_READY  in  1  memory accepts or completes the current transfer this cycle
- RD_DATA  in  AW  memory read data, valid when MEM_REQ & MEM_READY & L
- RF_RD  in  AW  register-file read data for RF_RA (combinational)
- BUSY  out  1  operation in progress; core stall
- DONE  out  1  one-cycle completion pulse
- RF_RA  out  4  register-file read address (stores)
- RF_WA  out  4  register-file write address
- RF_WE  out  1  register-file write enable
- RF_WD  out  AW  register-file write data
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  memory write strobe
- MEM_ADDR  out  AW  memory address
- MEM_WD  out  AW  memory write data
- PC_LOAD  out  1  load of R15 this cycle
- PC_WD  out  AW  value for PC when PC_LOAD = 1

Behaviour:
- States: IDLE, XFER, FIN. Reset (async, any state) forces IDLE; all outputs are 0; the pending list, counter and address registers are cleared. No write is issued after reset asserts.
- IDLE, START = 1:
  - Latch L, W, RN, REGLIST and BASE.
  - N = popcount(REGLIST), range 0..16, held in 5 bits.
  - Start address: IA (P=0,U=1) = BASE; IB (P=1,U=1) = BASE+4; DA (P=0,U=0) = BASE-4N+4; DB (P=1,U=0) = BASE-4N.
  - Writeback value: U ? BASE+4N : BASE-4N, modulo 2^AW.
  - Next state: XFER if N > 0, else FIN.
- XFER:
  - Current register = lowest set bit of the pending list. Registers go in ascending order to ascending addresses.
  - MEM_REQ = 1; MEM_ADDR = current address; MEM_WE = ~L.
  - Store: RF_RA = current register; MEM_WD = RF_RD.
  - MEM_ADDR, MEM_WE and MEM_WD stay stable while MEM_READY = 0.
  - Transfer completes in a cycle with MEM_READY = 1. On completion:
    - Clear the pending bit; address += 4.
    - Load to Ri with i < 15: RF_WE = 1, RF_WA = i, RF_WD = RD_DATA, all in the same cycle (combinational on MEM_READY).
    - Load to R15: PC_LOAD = 1, PC_WD = RD_DATA, RF_WE = 0.
  - Last pending bit completed: next state is FIN.
- FIN (one cycle), DONE = 1:
  - If W = 1, RN != 15, and not (L = 1 and REGLIST[RN] = 1): RF_WE = 1, RF_WA = RN, RF_WD = writeback value.
  - Otherwise no writeback; the loaded value wins over writeback.
  - Next state: IDLE.
- Timing:
  - BUSY = 1 in XFER and FIN.
  - START while BUSY is ignored.
  - With zero wait states, N transfers take START at cycle 0, transfers in cycles 1..N, and DONE in cycle N+1.
- Empty list: no memory requests are issued; DONE comes in cycle 1 with writeback per the rules above.
- Address wrap-around is modulo 2^AW, with no fault.
- Outside the active conditions, RF_WE, MEM_REQ, MEM_WE, PC_LOAD and DONE are 0.

Test Plan:
- LDM IA, BASE=0x100, REGLIST=0x000B, W=1, RN=4, MEM_READY always 1 -> MEM_ADDR 0x100/0x104/0x108 in cycles 1-3; RF_WA 0/1/3 take RD_DATA; cycle 4 DONE with R4 written 0x10C.
- STM DB, BASE=0x200, REGLIST=0x8006, RN=13, W=1 -> stores R1@0x1F4, R2@0x1F8, R15@0x1FC (RF_RA=15); R13 written 0x1F4; MEM_WE=1 on each request.
- LDM IB, REGLIST=0x8010, MEM_READY low for 2 cycles per transfer -> address held stable; R4 loaded from BASE+4; PC_LOAD with PC_WD = data from BASE+8; DONE at cycle 7.
- LDM IA, RN=2, REGLIST=0x0004, W=1 -> R2 receives loaded value; no writeback in FIN.
- REGLIST=0, W=1, U=0, BASE=0x40 -> no MEM_REQ; DONE in cycle 1; RN written 0x40.
- RST_N low mid-XFER after one transfer, START re-pulsed during BUSY before that -> second START ignored; on reset, all outputs 0 and no further RF_WE; a fresh START after reset runs the full sequence.
